fft_frame_sequencer: RTL

//  Front-end controller for the 4-point FFT core. Collects a serial sample stream into
//  4-point frames, launches the core with a one-cycle new_t pulse, tracks its done

---
 rtl/fft_frame_sequencer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: frames a serial sample stream for the 4-point FFT core,
// launches it, waits on its done handshake and streams the four bins out.
// Optional core watchdog: define FFT_SEQ_TIMEOUT_EN.
module fft_frame_sequencer #(
    parameter int DW      = 10,
    parameter int FW      = 16,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 8
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    s_data,
    output logic             fft_new_t,
    output logic [DW-1:0]    fft_pt0,
    output logic [DW-1:0]    fft_pt1,
    output logic [DW-1:0]    fft_pt2,
    output logic [DW-1:0]    fft_pt3,
    input  logic             fft_done,
    input  logic [FW-1:0]    fft_freq0,
    input  logic [FW-1:0]    fft_freq1,
    input  logic [FW-1:0]    fft_freq2,
    input  logic [FW-1:0]    fft_freq3,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [FW-1:0]    m_data,
    output logic             m_last,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             err
);

    typedef enum logic [2:0] {
        S_FILL,
        S_LAUNCH,
        S_WAIT_LO,
        S_WAIT_HI,
        S_DRAIN
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [1:0]       r_idx;
    logic [1:0]       r_k;
    logic [DW-1:0]    r_pt  [4];
    logic [FW-1:0]    r_bin [4];
    logic             r_new_t;
    logic [CNT_W-1:0] r_frame_cnt;

    logic w_accept;
    logic w_latch;
    logic w_beat;
    logic w_to_hit;

`ifdef FFT_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_tcnt;
    logic          r_err;
    logic          w_waiting;

    assign w_waiting = (r_state == S_WAIT_LO) || (r_state == S_WAIT_HI);
    assign w_to_hit  = w_waiting && (r_tcnt == TW'(TIMEOUT - 1));
    assign err       = r_err;

    // Watchdog: restart on every state entry, count while waiting on the core
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            r_tcnt <= '0;
        end else if (w_next != r_state) begin
            r_tcnt <= '0;
        end else if (w_waiting) begin
            r_tcnt <= r_tcnt + TW'(1);
        end
    end

    // Sticky error once the core misses its handshake
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_to_hit) begin
            r_err <= 1'b1;
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT > 0);
    assign w_to_hit         = 1'b0;
    assign err              = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_latch  = 1'b0;
        w_beat   = 1'b0;
        unique case (r_state)
            S_FILL: begin
                w_accept = s_valid;
                if (s_valid && (r_idx == 2'd3)) begin
                    w_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_next = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!fft_done) begin
                    w_next = S_WAIT_HI;
                end else if (w_to_hit) begin
                    w_next = S_FILL;
                end
            end
            S_WAIT_HI: begin
                if (fft_done) begin
                    w_latch = 1'b1;
                    w_next  = S_DRAIN;
                end else if (w_to_hit) begin
                    w_next = S_FILL;
                end
            end
            S_DRAIN: begin
                w_beat = m_ready;
                if (m_ready && (r_k == 2'd3)) begin
                    w_next = S_FILL;
                end
            end
            default: begin
                w_next = S_FILL;
            end
        endcase
    end

    // Sample capture into the frame buffer
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            r_idx <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                r_pt[i] <= '0;
            end
        end else if (w_accept) begin
            r_pt[r_idx] <= s_data;
            r_idx       <= r_idx + 2'd1;
        end
    end

    // Launch pulse, high exactly for the LAUNCH cycle
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            r_new_t <= 1'b0;
        end else begin
            r_new_t <= (w_next == S_LAUNCH);
        end
    end

    // Bin latch on done rising, then per-beat output index
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            r_k <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                r_bin[i] <= '0;
            end
        end else if (w_latch) begin
            r_k      <= 2'd0;
            r_bin[0] <= fft_freq0;
            r_bin[1] <= fft_freq1;
            r_bin[2] <= fft_freq2;
            r_bin[3] <= fft_freq3;
        end else if (w_beat) begin
            r_k <= r_k + 2'd1;
        end
    end

    // Completed-frame counter, wraps naturally
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            r_frame_cnt <= '0;
        end else if (w_beat && (r_k == 2'd3)) begin
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
        end
    end

    assign s_ready   = (r_state == S_FILL);
    assign busy      = (r_state != S_FILL);
    assign fft_new_t = r_new_t;
    assign fft_pt0   = r_pt[0];
    assign fft_pt1   = r_pt[1];
    assign fft_pt2   = r_pt[2];
    assign fft_pt3   = r_pt[3];
    assign m_valid   = (r_state == S_DRAIN);
    assign m_data    = r_bin[r_k];
    assign m_last    = (r_state == S_DRAIN) && (r_k == 2'd3);
    assign frame_cnt = r_frame_cnt;

endmodule
